// File: rtl/rocc_cmd_issuer_pkg.sv
// rocc_pkg: shared constants, state encoding and status codes for the RoCC command issuer.
package rocc_pkg;
   localparam int F7_W  = 7;
   localparam int REG_W = 5;
   localparam int OPC_W = 2;
   localparam logic [F7_W-1:0] OP1 = 7'd1;
   localparam logic [F7_W-1:0] OP2 = 7'd2;
   localparam logic [F7_W-1:0] OP3 = 7'd3;
   localparam logic [F7_W-1:0] OP4 = 7'd4;
   localparam logic [F7_W-1:0] OP5 = 7'd5;
   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ILL = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;
   typedef enum logic [2:0] {IDLE, ISSUE, ACK, BUSY, DRAIN, REPORT} state_t;
   function automatic logic legal_op(input logic [F7_W-1:0] f);
      return f inside {[OP1:OP5]};
   endfunction
endpackage

// File: rtl/rocc_cmd_issuer_if.sv
// rocc_cmd_issuer_if: command bus between the issuer (master) and the accelerator (slave).
interface rocc_cmd_issuer_if #(
   parameter int INST_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   logic [INST_WIDTH-6:0] inst;
   logic [DATA_WIDTH-1:0] rs1;
   logic [DATA_WIDTH-1:0] rs2;
   logic                  valid;
   logic                  ready;
   modport master(output inst, rs1, rs2, valid, input ready);
   modport slave(input inst, rs1, rs2, valid, output ready);
endinterface

// File: rtl/rocc_cmd_issuer_fifo.sv
// rocc_cmd_fifo: show-ahead synchronous FIFO; a reset discards contents by clearing the pointers.
module rocc_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic             do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rp];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(do_push);
         rp    <= rp + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/rocc_cmd_issuer.sv
// rocc_cmd_issuer: buffers host commands, issues them to the accelerator and reports
// completion, latency, timeout and illegal-opcode status.
module rocc_cmd_issuer
   import rocc_pkg::*;
#(
   parameter int         INST_WIDTH     = 32,
   parameter int         DATA_WIDTH     = 64,
   parameter int         FIFO_DEPTH     = 4,
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [1:0] CUSTOM_OPC     = 2'b00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [F7_W-1:0]       cmd_funct7,
   input  logic [REG_W-1:0]      cmd_rd,
   input  logic [DATA_WIDTH-1:0] cmd_rs1,
   input  logic [DATA_WIDTH-1:0] cmd_rs2,
   rocc_cmd_issuer_if.master     acc,
   output logic                  done_valid,
   output logic [REG_W-1:0]      done_rd,
   output logic [15:0]           done_cycles,
   output logic [1:0]            done_status,
   output logic                  busy,
   output logic                  err,
   input  logic                  err_clr
);
   localparam int FW = F7_W + REG_W + 2 * DATA_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t                state, state_nx;
   logic [FW-1:0]         head;
   logic [F7_W-1:0]       h_f7;
   logic [REG_W-1:0]      h_rd, rd_q;
   logic [DATA_WIDTH-1:0] h_rs1, h_rs2;
   logic                  full, empty, pop, tmo;
   logic [CW-1:0]         count;
   logic [15:0]           cnt, cnt_nx;
   logic [1:0]            status_nx;
   assign {h_f7, h_rd, h_rs1, h_rs2} = head;
   assign cmd_ready = !full;
   assign busy      = state != IDLE || count != '0;
   assign pop       = state == IDLE && !empty;
   rocc_cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk, .rst, .push(cmd_valid), .pop,
      .wdata({cmd_funct7, cmd_rd, cmd_rs1, cmd_rs2}),
      .rdata(head), .full, .empty, .count
   );
   // A completing BUSY cycle takes priority over a timeout landing on the same edge.
   always_comb begin
      state_nx  = state;
      status_nx = ST_OK;
      cnt_nx    = (state == ACK || state == BUSY) ? (cnt == 16'hFFFF ? cnt : cnt + 16'd1)
                : (pop || (state == ISSUE && acc.ready)) ? 16'd0 : cnt;
      tmo       = (state == ACK || (state == BUSY && !acc.ready)) && cnt_nx == 16'(TIMEOUT_CYCLES);
      case (state)
         IDLE:    if (pop) begin
                     state_nx  = legal_op(h_f7) ? ISSUE : REPORT;
                     status_nx = legal_op(h_f7) ? ST_OK : ST_ILL;
                  end
         ISSUE:   state_nx = acc.ready ? ACK : ISSUE;
         ACK:     state_nx = tmo ? DRAIN : !acc.ready ? BUSY : ACK;
         BUSY:    state_nx = tmo ? DRAIN : acc.ready ? REPORT : BUSY;
         DRAIN:   if (acc.ready) begin
                     state_nx  = REPORT;
                     status_nx = ST_TMO;
                  end
         REPORT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rd_q        <= '0;
         acc.inst    <= '0;
         acc.rs1     <= '0;
         acc.rs2     <= '0;
         acc.valid   <= 1'b0;
         done_valid  <= 1'b0;
         done_rd     <= '0;
         done_cycles <= '0;
         done_status <= '0;
         err         <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         acc.valid  <= state_nx == ISSUE;
         done_valid <= state_nx == REPORT;
         err        <= tmo || (err && !err_clr);
         if (pop) begin
            rd_q     <= h_rd;
            acc.inst <= (INST_WIDTH-5)'({h_f7, 10'd0, 3'b111, h_rd, CUSTOM_OPC});
            acc.rs1  <= h_rs1;
            acc.rs2  <= h_rs2;
         end
         if (state_nx == REPORT) begin
            done_rd     <= pop ? h_rd : rd_q;
            done_cycles <= cnt_nx;
            done_status <= status_nx;
         end
      end
endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// tb_rocc_cmd_issuer: directed and randomized checks of the issuer against a queue-based
// reference model and a behavioural accelerator.
module tb_rocc_cmd_issuer;
   localparam int DW  = 64;
   localparam int TMO = 16;
   typedef struct { logic [26:0] inst; logic [63:0] rs1, rs2; int d; } pay_t;
   typedef struct { logic [4:0] rd; logic [1:0] st; logic [15:0] cyc; } res_t;
   logic          clk = 0, rst = 1, cmd_valid = 0, err_clr = 0, hold = 0;
   logic          cmd_ready, done_valid, busy, err;
   logic [6:0]    cmd_funct7 = 0;
   logic [4:0]    cmd_rd = 0, done_rd;
   logic [DW-1:0] cmd_rs1 = 0, cmd_rs2 = 0;
   logic [15:0]   done_cycles;
   logic [1:0]    done_status;
   pay_t          pq[$];
   res_t          eq[$];
   int            vectors = 0, miscompares = 0;
   rocc_cmd_issuer_if #(.INST_WIDTH(32), .DATA_WIDTH(DW)) acc();
   rocc_cmd_issuer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_funct7(cmd_funct7), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .acc(acc), .done_valid(done_valid), .done_rd(done_rd), .done_cycles(done_cycles),
      .done_status(done_status), .busy(busy), .err(err), .err_clr(err_clr)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   // Expected result follows from the accelerator's busy length d: ready returns d+1 cycles
   // after acceptance, anything beyond TMO cycles is a timeout.
   task automatic push(input logic [6:0] f, input logic [4:0] rd, input logic [63:0] a,
                       input logic [63:0] b, input int d);
      int n;
      pay_t p;
      res_t r;
      logic lg;
      n = 0;
      cmd_valid = 1; cmd_funct7 = f; cmd_rd = rd; cmd_rs1 = a; cmd_rs2 = b;
      while (!cmd_ready && n < 300) begin step(); n++; end
      if (!cmd_ready) chk("push_wait", cmd_ready, 1);
      lg = f >= 7'd1 && f <= 7'd5;
      r.rd  = rd;
      r.st  = !lg ? 2'b01 : (d + 1 <= TMO) ? 2'b00 : 2'b10;
      r.cyc = !lg ? 16'd0 : (d + 1 <= TMO) ? 16'(d + 1) : 16'(TMO);
      if (lg) begin
         p.inst = 27'((int'(f) << 20) + (7 << 7) + (int'(rd) << 2));
         p.rs1 = a; p.rs2 = b; p.d = d;
         pq.push_back(p);
      end
      eq.push_back(r);
      step();
      cmd_valid = 0;
   endtask
   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || eq.size() != 0) && n < 3000) begin step(); n++; end
      chk("idle_busy", busy, 0);
      chk("idle_sb", eq.size(), 0);
   endtask
   // Accelerator: drops ready for d cycles after each accepted command.
   initial begin : accel
      int rem;
      logic rdy, acc_f;
      pay_t p;
      rem = 0; rdy = 1; acc_f = 0; p.d = 1;
      acc.ready = 1;
      forever begin
         step();
         if (rst) begin rem = 0; rdy = 1; acc_f = 0; end
         else if (acc_f) begin rem = p.d; rdy = 0; end
         else if (rem > 0) begin rem--; rdy = rem == 0; end
         acc.ready = rdy && !hold;
         acc_f = !rst && acc.valid && acc.ready;
         if (acc_f) begin
            if (pq.size() == 0) begin chk("unexpected_valid", acc.valid, 0); p.d = 1; end
            else begin
               p = pq.pop_front();
               chk("inst", acc.inst, p.inst);
               chk("rs1", acc.rs1, p.rs1);
               chk("rs2", acc.rs2, p.rs2);
            end
         end
      end
   end
   initial begin : mon
      res_t r;
      forever begin
         step();
         if (done_valid && !rst) begin
            if (eq.size() == 0) chk("unexpected_done", done_valid, 0);
            else begin
               r = eq.pop_front();
               chk("done_rd", done_rd, r.rd);
               chk("done_status", done_status, r.st);
               chk("done_cycles", done_cycles, r.cyc);
               if (r.st == 2'b10) begin
                  chk("err_set", err, 1);
                  err_clr = 1;
                  step();
                  err_clr = 0;
                  chk("err_clr", err, 0);
               end else chk("err_idle", err, 0);
            end
         end
      end
   end
   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin : main
      int n;
      logic seen;
      logic [6:0] f;
      step();
      chk("rst_valid", acc.valid, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_inst", acc.inst, 0);
      chk("rst_rs", acc.rs1 | acc.rs2, 0);
      chk("rst_done_fields", {done_rd, done_cycles, done_status}, 0);
      rst = 0;
      step(2);
      // single command: valid one cycle after the push edge
      push(7'd1, 5'd3, 64'h3F800000_40000000, 64'h40400000_40800000, 10);
      chk("lat_pre", acc.valid, 0);
      step();
      chk("lat_valid", acc.valid, 1);
      chk("inst_pack", acc.inst, 27'h010038C);
      wait_idle();
      // illegal funct7: reported one cycle after the pop, accelerator untouched
      push(7'd9, 5'd7, {$urandom, $urandom}, {$urandom, $urandom}, 1);
      step();
      chk("ill_done", done_valid, 1);
      chk("ill_novalid", acc.valid, 0);
      wait_idle();
      // back-to-back
      push(7'd2, 5'd4, {$urandom, $urandom}, {$urandom, $urandom}, 3);
      push(7'd4, 5'd5, {$urandom, $urandom}, {$urandom, $urandom}, 3);
      n = 0;
      while (!done_valid && n < 100) begin step(); n++; end
      chk("b2b_done", done_valid, 1);
      step();
      chk("b2b_gap", acc.valid, 0);
      step();
      chk("b2b_valid", acc.valid, 1);
      wait_idle();
      // timeout
      push(7'd3, 5'd9, {$urandom, $urandom}, {$urandom, $urandom}, 25);
      step(2);
      chk("tmo_accept", acc.valid, 0);
      step(15);
      chk("tmo_err_pre", err, 0);
      step();
      chk("tmo_err", err, 1);
      seen = 0; n = 0;
      while (!acc.ready && n < 100) begin seen |= done_valid; step(); n++; end
      chk("tmo_nodone", seen, 0);
      wait_idle();
      // FIFO full: one command stalled in ISSUE plus four buffered
      hold = 1;
      step(2);
      for (int i = 1; i <= 5; i++)
         push(7'(1 + i % 5), 5'(i), {$urandom, $urandom}, {$urandom, $urandom}, 2);
      chk("full_ready", cmd_ready, 0);
      chk("full_busy", busy, 1);
      hold = 0;
      push(7'd5, 5'd6, {$urandom, $urandom}, {$urandom, $urandom}, 2);
      wait_idle();
      // asynchronous reset while BUSY with two commands queued
      push(7'd1, 5'd10, {$urandom, $urandom}, {$urandom, $urandom}, 12);
      push(7'd2, 5'd11, {$urandom, $urandom}, {$urandom, $urandom}, 1);
      push(7'd3, 5'd12, {$urandom, $urandom}, {$urandom, $urandom}, 1);
      step(4);
      #3 rst = 1;
      #1;
      chk("arst_valid", acc.valid, 0);
      chk("arst_cmd_ready", cmd_ready, 1);
      chk("arst_busy", busy, 0);
      pq.delete();
      eq.delete();
      step();
      rst = 0;
      seen = 0;
      repeat (30) begin step(); seen |= done_valid | acc.valid; end
      chk("arst_quiet", seen, 0);
      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         f = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(1, 5)) : 7'($urandom_range(0, 127));
         push(f, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 9) < 8) ? $urandom_range(1, 12) : $urandom_range(13, 20));
         if ($urandom_range(0, 3) == 0) step($urandom_range(1, 20));
      end
      wait_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
